// File: rtl/msrv32_lsu_ctrl_if.sv
// Pipeline-request, AHB-style bus and load-unit signals of the LSU controller.
// slave = the controller itself; master = the pipeline/bus environment around it.
interface msrv32_lsu_ctrl_if;
  logic        mem_req_in;
  logic        mem_we_in;
  logic [31:0] addr_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic [31:0] store_data_in;
  logic        req_ready_out;
  logic        stall_out;

  logic        bus_valid_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [3:0]  bus_wmask_out;
  logic [31:0] bus_wdata_out;
  logic        hready_in;
  logic        hresp_in;
  logic [31:0] hrdata_in;

  logic [1:0]  load_size_out;
  logic        load_unsigned_out;
  logic [1:0]  iadder_1_to_0_out;
  logic [31:0] load_data_out;
  logic        ahb_resp_out;
  logic        done_out;
  logic        misaligned_out;

  modport slave (
    input  mem_req_in, mem_we_in, addr_in, size_in, unsigned_in, store_data_in,
    input  hready_in, hresp_in, hrdata_in,
    output req_ready_out, stall_out,
    output bus_valid_out, bus_we_out, bus_addr_out, bus_wmask_out, bus_wdata_out,
    output load_size_out, load_unsigned_out, iadder_1_to_0_out, load_data_out,
    output ahb_resp_out, done_out, misaligned_out
  );

  modport master (
    output mem_req_in, mem_we_in, addr_in, size_in, unsigned_in, store_data_in,
    output hready_in, hresp_in, hrdata_in,
    input  req_ready_out, stall_out,
    input  bus_valid_out, bus_we_out, bus_addr_out, bus_wmask_out, bus_wdata_out,
    input  load_size_out, load_unsigned_out, iadder_1_to_0_out, load_data_out,
    input  ahb_resp_out, done_out, misaligned_out
  );
endinterface

// File: rtl/msrv32_lsu_ctrl.sv
// Load/store unit controller: turns one pipeline memory request into a single
// address+data bus transfer and reports completion or misalignment.
module msrv32_lsu_ctrl (
  input  logic             clk_in,
  input  logic             rst_n_in,
  msrv32_lsu_ctrl_if.slave lsu
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic        misaligned, accept;
  logic [3:0]  wmask_next;
  logic [31:0] wdata_next;

  logic        bus_valid_reg, bus_we_reg, done_reg, misaligned_reg;
  logic        ahb_resp_reg, load_unsigned_reg;
  logic [31:0] bus_addr_reg, bus_wdata_reg, load_data_reg;
  logic [3:0]  bus_wmask_reg;
  logic [1:0]  load_size_reg, iadder_reg;

  assign misaligned = (lsu.size_in == 2'b01 && lsu.addr_in[0]) ||
                      (lsu.size_in[1] && lsu.addr_in[1:0] != 2'b00);
  assign accept     = lsu.mem_req_in && (state_reg == IDLE) && !misaligned;

  // Per byte lane: enable and replicated store data for byte/half/word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign wmask_next[gi] = lsu.size_in[1] ? 1'b1 :
                              lsu.size_in[0] ? (lsu.addr_in[1] == LANE[1]) :
                                               (lsu.addr_in[1:0] == LANE);
      assign wdata_next[8*gi +: 8] = lsu.size_in[1] ? lsu.store_data_in[8*gi +: 8] :
                                     lsu.size_in[0] ? lsu.store_data_in[8*(gi%2) +: 8] :
                                                      lsu.store_data_in[7:0];
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ADDR;
      ADDR:    if (lsu.hready_in) state_next = DATA;
      DATA:    if (lsu.hready_in) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus_valid_reg     <= 1'b0;
      bus_we_reg        <= 1'b0;
      bus_addr_reg      <= '0;
      bus_wmask_reg     <= '0;
      bus_wdata_reg     <= '0;
      load_data_reg     <= '0;
      ahb_resp_reg      <= 1'b0;
      done_reg          <= 1'b0;
      misaligned_reg    <= 1'b0;
      load_size_reg     <= '0;
      load_unsigned_reg <= 1'b0;
      iadder_reg        <= '0;
    end else begin
      // done_reg rises exactly on the DATA->DONE edge, so it tracks the DONE state.
      done_reg       <= (state_reg == DATA) && lsu.hready_in;
      misaligned_reg <= lsu.mem_req_in && (state_reg == IDLE) && misaligned;
      if (accept) begin
        bus_valid_reg     <= 1'b1;
        bus_we_reg        <= lsu.mem_we_in;
        bus_addr_reg      <= {lsu.addr_in[31:2], 2'b00};
        bus_wmask_reg     <= wmask_next;
        bus_wdata_reg     <= wdata_next;
        load_size_reg     <= lsu.size_in;
        load_unsigned_reg <= lsu.unsigned_in;
        iadder_reg        <= lsu.addr_in[1:0];
      end else if (state_reg == ADDR && lsu.hready_in) begin
        bus_valid_reg <= 1'b0;
      end
      if (state_reg == DATA && lsu.hready_in) begin
        ahb_resp_reg <= lsu.hresp_in;
        if (!bus_we_reg) load_data_reg <= lsu.hrdata_in;
      end
    end
  end

  assign lsu.req_ready_out     = (state_reg == IDLE);
  assign lsu.stall_out         = ((state_reg == IDLE) && lsu.mem_req_in && !misaligned) ||
                                 (state_reg == ADDR) || (state_reg == DATA);
  assign lsu.bus_valid_out     = bus_valid_reg;
  assign lsu.bus_we_out        = bus_we_reg;
  assign lsu.bus_addr_out      = bus_addr_reg;
  assign lsu.bus_wmask_out     = bus_wmask_reg;
  assign lsu.bus_wdata_out     = bus_wdata_reg;
  assign lsu.load_size_out     = load_size_reg;
  assign lsu.load_unsigned_out = load_unsigned_reg;
  assign lsu.iadder_1_to_0_out = iadder_reg;
  assign lsu.load_data_out     = load_data_reg;
  assign lsu.ahb_resp_out      = ahb_resp_reg;
  assign lsu.done_out          = done_reg;
  assign lsu.misaligned_out    = misaligned_reg;
endmodule

// File: doc/msrv32_lsu_ctrl.md
MSRV32_LSU_CTRL -- requirements
Module: msrv32_lsu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_in input 1 (rising edge); rst_n_in input 1 (async assert, active-low).
REQ-002 The block SHALL have these pipeline ports: mem_req_in input 1, request valid; mem_we_in input 1, 1=store 0=load; addr_in input 32, effective address; size_in input 2, 00 byte 01 half 10/11 word; unsigned_in input 1, zero-extend load; store_data_in input 32, store data LSB-aligned; req_ready_out output 1, request accepted this cycle; stall_out output 1, hold pipeline.
REQ-003 The block SHALL have these bus ports: bus_valid_out output 1, address phase valid; bus_we_out output 1; bus_addr_out output 32, word-aligned; bus_wmask_out output 4, byte enables; bus_wdata_out output 32; hready_in input 1, transfer ready; hresp_in input 1, error response; hrdata_in input 32.
REQ-004 The block SHALL have these load-unit and status ports: load_size_out output 2; load_unsigned_out output 1; iadder_1_to_0_out output 2; load_data_out output 32, captured hrdata; ahb_resp_out output 1, error flag for the load unit; done_out output 1, one-cycle completion pulse; misaligned_out output 1, one-cycle exception pulse.

Function
REQ-005 The FSM SHALL have states IDLE, ADDR, DATA and DONE.
REQ-006 req_ready_out SHALL equal 1 only in IDLE; a request SHALL be accepted when mem_req_in=1 and req_ready_out=1.
REQ-007 A misaligned request SHALL NOT start a bus transfer; it SHALL pulse misaligned_out for one cycle and stay in IDLE. A request is misaligned when it is a half with addr_in[0]=1, or a word with addr_in[1:0]!=00.
REQ-008 On an aligned accept, the block SHALL register we, addr, size, unsigned and store data, then go IDLE->ADDR.
REQ-009 In ADDR the block SHALL drive bus_valid_out=1, bus_addr_out={addr[31:2],2'b00}, bus_we_out and bus_wmask_out. It SHALL hold them until hready_in=1, then go to DATA.
REQ-010 In DATA, bus_wdata_out SHALL be valid for stores. When hready_in=1 the block SHALL capture hrdata_in into load_data_out (loads only) and hresp_in into ahb_resp_out, then go to DONE. While hready_in=0 it SHALL stay in DATA.
REQ-011 In DONE the block SHALL drive done_out=1 for exactly one cycle, then return to IDLE.
REQ-012 load_data_out and ahb_resp_out SHALL hold until the next DONE.
REQ-013 bus_wmask_out SHALL be: byte 0001<<addr[1:0]; half 0011 if addr[1]=0, else 1100; word 1111.
REQ-014 bus_wmask_out SHALL be driven for loads as well as stores.
REQ-015 bus_wdata_out SHALL be {4{data[7:0]}} for byte, {2{data[15:0]}} for half, and data for word.
REQ-016 load_size_out, load_unsigned_out and iadder_1_to_0_out SHALL reflect the registered request from ADDR through the next accept.
REQ-017 stall_out SHALL be combinational: 1 when (IDLE and mem_req_in and not misaligned) or in ADDR or DATA; 0 in DONE.
REQ-018 With zero wait states, the block SHALL reach done_out 3 cycles after accept; each hready_in=0 cycle SHALL add one cycle.
REQ-019 mem_req_in outside IDLE SHALL be ignored; the pipeline is stalled and re-presents the request.
REQ-020 On an error response (hresp_in=1), the block SHALL still pulse done_out, with ahb_resp_out=1; no retry.

Reset
REQ-021 While rst_n_in=0, the block SHALL force state IDLE.
REQ-022 While rst_n_in=0, the block SHALL hold all registered outputs at 0: bus_valid_out, bus_we_out, bus_addr_out, bus_wmask_out, bus_wdata_out, load_data_out, ahb_resp_out, done_out, misaligned_out, load_size_out, load_unsigned_out, iadder_1_to_0_out.
REQ-023 While rst_n_in=0, req_ready_out SHALL be 1.
REQ-024 Reset asserted mid-transfer SHALL abort it immediately, with no done_out pulse.
REQ-025 After reset release, the block SHALL accept on the first clock edge.

Verification
REQ-026 Byte load: addr 0x1003, size 00, hready_in=1, hrdata 0xAABBCCDD -> bus_addr 0x1000, wmask 1000, done 3 cycles after accept, load_data 0xAABBCCDD, iadder_1_to_0_out=11.
REQ-027 Half store: addr 0x2002, data 0x0000BEEF -> wmask 1100, wdata 0xBEEFBEEF, bus_we=1.
REQ-028 Word load with 2 wait cycles in DATA -> done 5 cycles after accept; stall_out high throughout, low in DONE.
REQ-029 Word request at addr 0x3001 -> misaligned_out one pulse; bus_valid_out stays 0; next cycle ready.
REQ-030 Load with hresp_in=1 -> done_out pulse with ahb_resp_out=1.
REQ-031 Reset asserted in DATA -> all outputs 0 asynchronously; no done_out pulse; req_ready_out=1.
